imem_loader: RTL

- Writer side of the 512-byte big-endian instruction memory: receives a program image as a byte stream and writes it, one byte per cycle, into the memory write port.
- Holds the pipeline in reset while loading; releases it only after a good checksum.
- Sits between the host byte link (valid/ready) and the instruction memory write port, ahead of the fetch stage.

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_loader.sv | 116 +++++++++++
 2 files changed

// File: rtl/imem_loader_pkg.sv
// Shared instruction-memory definitions: loader state encoding and memory geometry,
// used by the loader, the instruction memory and the fetch stage.
package imem_loader_pkg;

  localparam int IMEM_BYTES  = 512;
  localparam int IMEM_ADDR_W = 9;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

endpackage

// File: rtl/imem_loader.sv
// Streams a length-prefixed, checksummed program image into the instruction memory
// write port one byte per cycle and holds the CPU in reset until a good image is in.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_BYTES = IMEM_BYTES,
  parameter int ADDR_W    = IMEM_ADDR_W,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error,
  output state_t            state
);

  // Wide enough that a full-memory length (e.g. 512) is representable.
  localparam int          CNT_W   = $clog2(MEM_BYTES + 1);
  localparam logic [15:0] MAX_LEN = 16'(MEM_BYTES - BASE_ADDR);

  // Handshake: a byte moves on a rising edge where rx_valid && rx_ready; rx_ready
  // depends only on state, so the host may hold rx_valid/rx_data until it is taken.
  state_t             state_next;
  logic [7:0]         len_hi;
  logic [CNT_W-1:0]   len_last;
  logic [CNT_W-1:0]   count;
  logic [7:0]         sum;
  logic               accept;
  logic               start_ok;
  logic [15:0]        len_rx;
  logic [7:0]         csum_total;
  logic [ADDR_W-1:0]  wr_addr;

  assign rx_ready   = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                      (state == S_DATA)   || (state == S_CSUM);
  assign accept     = rx_valid && rx_ready;
  assign start_ok   = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
  assign len_rx     = {len_hi, rx_data};
  assign csum_total = sum + rx_data;
  assign wr_addr    = ADDR_W'(BASE_ADDR) + count[ADDR_W-1:0];

  assign cpu_hold   = (state != S_DONE);
  assign load_done  = (state == S_DONE);
  assign load_error = (state == S_ERROR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (accept) state_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        // Oversize is rejected before any write, so the address can never wrap.
        if (accept) begin
          if (len_rx > MAX_LEN)    state_next = S_ERROR;
          else if (len_rx == 16'd0) state_next = S_CSUM;
          else                      state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (accept && (count == len_last)) state_next = S_CSUM;
      end
      S_CSUM: begin
        if (accept) state_next = (csum_total == 8'd0) ? S_DONE : S_ERROR;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'd0;
      len_hi    <= 8'd0;
      len_last  <= '0;
      count     <= '0;
      sum       <= 8'd0;
    end else begin
      mem_we <= 1'b0;
      if (start_ok) begin
        count <= '0;
        sum   <= 8'd0;
      end
      if ((state == S_LEN_HI) && accept) len_hi <= rx_data;
      if ((state == S_LEN_LO) && accept) len_last <= CNT_W'(len_rx - 16'd1);
      if ((state == S_DATA) && accept) begin
        mem_we    <= 1'b1;
        mem_addr  <= wr_addr;
        mem_wdata <= rx_data;
        sum       <= csum_total;
        count     <= count + CNT_W'(1);
      end
    end
  end

endmodule
